// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_pkg
//  Purpose  : Shared widths, bubble encoding and instruction field positions
//             for the LEGv8 pipeline.
//  Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;
  localparam int XLEN    = 64;
  localparam int INSTR_W = 32;

  // All-zero word decodes to the control-logic default case (no side effects)
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

  // Branch immediate field positions
  localparam int IMM26_LSB = 0;
  localparam int IMM26_W   = 26;
  localparam int IMM19_LSB = 5;
  localparam int IMM19_W   = 19;
endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage_if
//  Purpose  : Instruction-memory, decode-feedback and IF/ID outputs of the
//             fetch stage bundled as one interface.
//  Revision : 1.0 - initial release
// ============================================================================
interface fetch_stage_if;
  import cpu_pkg::*;

  logic [XLEN-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               br_taken;
  logic               uncond_br;
  logic               br_reg;
  logic [XLEN-1:0]    br_reg_val;
  logic [INSTR_W-1:0] id_instr;
  logic [XLEN-1:0]    id_pc;
  logic [XLEN-1:0]    id_pc_plus4;
  logic               id_valid;
  logic [31:0]        flush_count;

  // Fetch stage side
  modport master (
    output imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, flush_count,
    input  imem_rdata, stall, br_taken, uncond_br, br_reg, br_reg_val
  );

  // Memory / decode / hazard side
  modport slave (
    input  imem_addr, id_instr, id_pc, id_pc_plus4, id_valid, flush_count,
    output imem_rdata, stall, br_taken, uncond_br, br_reg, br_reg_val
  );
endinterface
`default_nettype wire

// File: rtl/fetch_stage_branch_target.sv
`default_nettype none
// ============================================================================
//  Module   : branch_target
//  Purpose  : Combinational redirect target: register target for BR,
//             otherwise PC-relative imm26 (B/BL) or imm19 (B.cond/CBZ).
//  Revision : 1.0 - initial release
// ============================================================================
module branch_target
  import cpu_pkg::*;
(
  input  wire logic [XLEN-1:0]    id_pc_i,
  // Only the low 26 bits carry immediates; opcode bits are not needed here
  input  wire logic [IMM26_W-1:0] id_instr_i,
  input  wire logic               uncond_br_i,
  input  wire logic               br_reg_i,
  input  wire logic [XLEN-1:0]    br_reg_val_i,
  output logic      [XLEN-1:0]    target_o
);

  logic [IMM26_W-1:0] imm26;
  logic [IMM19_W-1:0] imm19;
  logic [XLEN-1:0]    off26;
  logic [XLEN-1:0]    off19;

  assign imm26 = id_instr_i[IMM26_LSB +: IMM26_W];
  assign imm19 = id_instr_i[IMM19_LSB +: IMM19_W];

  // Word offsets: sign-extend and scale by 4
  assign off26 = {{(XLEN-IMM26_W-2){imm26[IMM26_W-1]}}, imm26, 2'b00};
  assign off19 = {{(XLEN-IMM19_W-2){imm19[IMM19_W-1]}}, imm19, 2'b00};

  // Register branch wins over PC-relative forms; sums wrap mod 2^64
  always_comb begin
    target_o = id_pc_i + off19;
    if (br_reg_i) begin
      target_o = br_reg_val_i;
    end else if (uncond_br_i) begin
      target_o = id_pc_i + off26;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_stage
//  Purpose  : PC register, IF/ID pipeline register, redirect/stall priority
//             and saturating redirect counter.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_stage
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = 64'h0,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DEFAULT
) (
  input  wire logic     clk,
  input  wire logic     reset_n,
  fetch_stage_if.master bus
);

  logic [XLEN-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0]    id_pc_q, id_pc_d;
  logic               id_valid_q, id_valid_d;
  logic [31:0]        flush_count_q, flush_count_d;
  logic [XLEN-1:0]    target;
  logic               redirect;

  branch_target u_branch_target (
    .id_pc_i      (id_pc_q),
    .id_instr_i   (id_instr_q[IMM26_W-1:0]),
    .uncond_br_i  (bus.uncond_br),
    .br_reg_i     (bus.br_reg),
    .br_reg_val_i (bus.br_reg_val),
    .target_o     (target)
  );

  // A bubble in ID can never redirect; a stall defers the redirect
  assign redirect = id_valid_q && !bus.stall && (bus.br_reg || bus.br_taken);

  // Next-state priority: stall, then redirect, then sequential fetch
  always_comb begin
    pc_d          = pc_q;
    id_instr_d    = id_instr_q;
    id_pc_d       = id_pc_q;
    id_valid_d    = id_valid_q;
    flush_count_d = flush_count_q;
    if (bus.stall) begin
      // hold everything
    end else if (redirect) begin
      pc_d       = target;
      id_instr_d = NOP_INSTR;
      id_pc_d    = pc_q;
      id_valid_d = 1'b0;
      if (flush_count_q != 32'hFFFF_FFFF) begin
        flush_count_d = flush_count_q + 32'd1;
      end
    end else begin
      pc_d       = pc_q + 64'd4;
      id_instr_d = bus.imem_rdata;
      id_pc_d    = pc_q;
      id_valid_d = 1'b1;
    end
  end

  // PC, IF/ID and counter registers with asynchronous reset
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      id_instr_q    <= NOP_INSTR;
      id_pc_q       <= '0;
      id_valid_q    <= 1'b0;
      flush_count_q <= '0;
    end else begin
      pc_q          <= pc_d;
      id_instr_q    <= id_instr_d;
      id_pc_q       <= id_pc_d;
      id_valid_q    <= id_valid_d;
      flush_count_q <= flush_count_d;
    end
  end

  assign bus.imem_addr   = pc_q;
  assign bus.id_instr    = id_instr_q;
  assign bus.id_pc       = id_pc_q;
  assign bus.id_pc_plus4 = id_pc_q + 64'd4;
  assign bus.id_valid    = id_valid_q;
  assign bus.flush_count = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_stage
//  Purpose  : Directed bench for fetch_stage with a behavioural reference
//             model and hand-computed literal expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_stage;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;

  fetch_stage_if bus ();

  fetch_stage #(
    .RESET_PC  (64'h100),
    .NOP_INSTR (32'h0000_0000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Program image: a few placed branches, everything else address-derived
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h200:       mem_word = 32'h17FF_FFFE;  // B  imm26 = -2
      64'h40:        mem_word = 32'h5400_00AB;  // B.LT imm19 = 5
      64'hDEAD_BEE0: mem_word = 32'h5400_00AB;  // B.LT imm19 = 5
      default:       mem_word = a[31:0] ^ 32'h5A5A_0000;
    endcase
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // Reference model state
  logic [63:0] m_pc;
  logic [31:0] m_instr;
  logic [63:0] m_id_pc;
  logic        m_valid;
  logic [31:0] m_flush;

  function automatic logic [63:0] model_target(input logic [63:0] pc,
                                               input logic [31:0] ins,
                                               input logic ub, input logic brr,
                                               input logic [63:0] v);
    longint off;
    if (brr) return v;
    if (ub) off = longint'($signed(ins[25:0])) * 4;
    else    off = longint'($signed(ins[23:5])) * 4;
    return pc + 64'(off);
  endfunction

  // Model advances from the architectural rules on each edge
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc    <= 64'h100;
      m_instr <= 32'h0;
      m_id_pc <= 64'h0;
      m_valid <= 1'b0;
      m_flush <= 32'h0;
    end else if (bus.stall) begin
      m_pc <= m_pc;
    end else if (m_valid && (bus.br_reg || bus.br_taken)) begin
      m_pc    <= model_target(m_id_pc, m_instr, bus.uncond_br, bus.br_reg, bus.br_reg_val);
      m_instr <= 32'h0;
      m_id_pc <= m_pc;
      m_valid <= 1'b0;
      m_flush <= (m_flush == 32'hFFFF_FFFF) ? m_flush : m_flush + 1;
    end else begin
      m_pc    <= m_pc + 64'd4;
      m_instr <= mem_word(m_pc);
      m_id_pc <= m_pc;
      m_valid <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Every cycle: DUT outputs must match the model
  always @(negedge clk) begin
    chk("mdl_imem_addr", bus.imem_addr, m_pc);
    chk("mdl_id_instr", 64'(bus.id_instr), 64'(m_instr));
    chk("mdl_id_pc", bus.id_pc, m_id_pc);
    chk("mdl_id_pc_plus4", bus.id_pc_plus4, m_id_pc + 64'd4);
    chk("mdl_id_valid", 64'(bus.id_valid), 64'(m_valid));
    chk("mdl_flush_count", 64'(bus.flush_count), 64'(m_flush));
  end

  task automatic drive(input logic s, input logic bt, input logic ub,
                       input logic brr, input logic [63:0] v);
    bus.stall      = s;
    bus.br_taken   = bt;
    bus.uncond_br  = ub;
    bus.br_reg     = brr;
    bus.br_reg_val = v;
  endtask

  // One cycle: inputs change just after the falling edge, result sampled 1ns after rising edge
  task automatic step(input logic s, input logic bt, input logic ub,
                      input logic brr, input logic [63:0] v);
    @(negedge clk);
    #1;
    drive(s, bt, ub, brr, v);
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},  bus.imem_addr, 64'h100);
    chk({tag, "_instr"}, 64'(bus.id_instr), 64'h0);
    chk({tag, "_pc"},    bus.id_pc, 64'h0);
    chk({tag, "_valid"}, 64'(bus.id_valid), 64'h0);
    chk({tag, "_flush"}, 64'(bus.flush_count), 64'h0);
  endtask

  initial begin
    int guard;
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_reset("rst");
    #1 reset_n = 1'b1;

    // Sequential fetch from RESET_PC
    @(posedge clk); #1;
    chk("seq1_addr", bus.imem_addr, 64'h104);
    chk("seq1_idpc", bus.id_pc, 64'h100);
    chk("seq1_valid", 64'(bus.id_valid), 64'h1);
    chk("seq1_instr", 64'(bus.id_instr), 64'h5A5A_0100);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("seq2_addr", bus.imem_addr, 64'h108);
    chk("seq2_idpc", bus.id_pc, 64'h104);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("seq3_addr", bus.imem_addr, 64'h10C);
    chk("seq3_idpc", bus.id_pc, 64'h108);
    chk("seq3_plus4", bus.id_pc_plus4, 64'h10C);

    // Run up to the unconditional B at 0x200
    guard = 0;
    while (bus.id_pc !== 64'h200 && guard < 200) begin
      step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
      guard++;
    end
    chk("reach_200", bus.id_pc, 64'h200);
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("b_addr", bus.imem_addr, 64'h1F8);
    chk("b_valid", 64'(bus.id_valid), 64'h0);
    chk("b_instr", 64'(bus.id_instr), 64'h0);
    chk("b_flush", 64'(bus.flush_count), 64'h1);
    // br_taken during the bubble must be ignored
    step(1'b0, 1'b1, 1'b1, 1'b0, 64'h0);
    chk("b_tgt_idpc", bus.id_pc, 64'h1F8);
    chk("b_tgt_addr", bus.imem_addr, 64'h1FC);
    chk("b_tgt_flush", 64'(bus.flush_count), 64'h1);

    // Conditional at 0x40, not taken then taken
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("c_idpc", bus.id_pc, 64'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    chk("nt_addr", bus.imem_addr, 64'h48);
    chk("nt_valid", 64'(bus.id_valid), 64'h1);
    chk("nt_flush", 64'(bus.flush_count), 64'h2);
    step(1'b0, 1'b0, 1'b0, 1'b1, 64'h40);
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("t_addr", bus.imem_addr, 64'h54);
    chk("t_flush", 64'(bus.flush_count), 64'h4);

    // BR priority over PC-relative
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 64'hDEAD_BEE0);
    chk("br_addr", bus.imem_addr, 64'hDEAD_BEE0);

    // Stall holds a pending redirect for two cycles
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0, 64'h0);
      chk("st_addr", bus.imem_addr, 64'hDEAD_BEE4);
      chk("st_idpc", bus.id_pc, 64'hDEAD_BEE0);
      chk("st_valid", 64'(bus.id_valid), 64'h1);
      chk("st_flush", 64'(bus.flush_count), 64'h5);
    end
    step(1'b0, 1'b1, 1'b0, 1'b0, 64'h0);
    chk("st_redir", bus.imem_addr, 64'hDEAD_BEF4);
    chk("st_redir_flush", 64'(bus.flush_count), 64'h6);

    // Asynchronous reset in the middle of a redirect cycle
    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    #1 drive(1'b0, 1'b0, 1'b0, 1'b1, 64'h3000);
    #2 reset_n = 1'b0;
    #1 chk_reset("arst");
    @(posedge clk); #1;
    chk_reset("arst_hold");
    @(negedge clk);
    #1 reset_n = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(posedge clk); #1;
    chk("rs_addr", bus.imem_addr, 64'h104);
    chk("rs_idpc", bus.id_pc, 64'h100);
    chk("rs_valid", 64'(bus.id_valid), 64'h1);
    chk("rs_flush", 64'(bus.flush_count), 64'h0);

    step(1'b0, 1'b0, 1'b0, 1'b0, 64'h0);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
